fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch and program-counter stage that sits directly upstream of `controlUnit`. It holds the PC and fetches 32-bit instructions from instruction memory over a busy-wait handshake. It presents each instruction, whose `INSTRUCTION[31:28]` drives `controlUnit.OPCODE`, for one execute slot. It then consumes `controlUnit`'s `BRAZ`, `BRANZ` and `BRAUNCOND` outputs plus the ALU zero flag to select the next PC.

## Interface
- `PC_WIDTH`, 32: PC register width; all PC arithmetic is modulo 2^PC_WIDTH.
- `RESET_PC`, 0: PC value loaded on reset.
- `IMEM_AW`, 10: instruction-memory word-address width.
- `CLK`  in  1: single clock, rising-edge.
- `RESET`  in  1: asynchronous, active-high reset.
- `BRAZ`  in  1: branch-if-zero, from `controlUnit`.
- `BRANZ`  in  1: branch-if-not-zero, from `controlUnit`.
- `BRAUNCOND`  in  1: unconditional branch, from `controlUnit`.
- `ZERO`  in  1: ALU zero flag for the current instruction.
- `STALL`  in  1: holds the current execute slot.
- `IMEM_READDATA`  in  32: instruction word returned by memory.
- `IMEM_BUSYWAIT`  in  1: memory busy; read data is not valid while high.
- `IMEM_READ`  out  1: read request.
- `IMEM_ADDR`  out  IMEM_AW: word address, equal to `PC[IMEM_AW+1:2]`.
- `INSTRUCTION`  out  32: registered instruction; opcode field is `[31:28]`, branch offset is `[7:0]`.
- `INSTR_VALID`  out  1: `INSTRUCTION` is in its execute slot.
- `PC`  out  PC_WIDTH: address of `INSTRUCTION`.

## Operation
- The FSM has three states: IDLE, FETCH and EXEC.
- IDLE:
  - This is the reset state. `IMEM_READ`=0 and `INSTR_VALID`=0.
  - Unconditionally goes to FETCH on the next edge.
- FETCH:
  - `IMEM_READ`=1 and `INSTR_VALID`=0.
  - On each edge where `IMEM_BUSYWAIT`=0, capture `IMEM_READDATA` into `INSTRUCTION` and go to EXEC.
  - Otherwise remain in FETCH; `PC` and `IMEM_ADDR` stay stable.
- EXEC:
  - `IMEM_READ`=0 and `INSTR_VALID`=1.
  - taken = `BRAUNCOND` | (`BRAZ` & `ZERO`) | (`BRANZ` & ~`ZERO`).
  - With `STALL`=1: stay in EXEC with no state change.
  - With `STALL`=0:
    - `PC` ← `PC`+4 + (taken ? sext(`INSTRUCTION[7:0]`)<<2 : 0).
    - Go to FETCH.
- Branch inputs are sampled only in EXEC with `STALL`=0.
  - X values on them in any other cycle must not propagate into `PC`.
  - In EXEC, X on `BRAZ`/`BRANZ` is treated as 0 when `BRAUNCOND`=1.
- Reset values, applied immediately when `RESET` asserts and held while it is high:
  - state = IDLE, `PC` = `RESET_PC`, `INSTRUCTION` = 0.
  - `INSTR_VALID` = 0, `IMEM_READ` = 0.
- A reset in the middle of FETCH abandons the read with no capture. The first fetch after release is from `RESET_PC`.

## Timing
- All outputs are registered or decoded from the state register only.
- `IMEM_ADDR` is derived from the `PC` register only. There are no combinational paths from inputs to outputs.
- Minimum 2 cycles per instruction: 1 FETCH cycle (no wait) plus 1 EXEC cycle. Each cycle of `IMEM_BUSYWAIT` adds one cycle.
- After reset release: IDLE for 1 cycle, then `IMEM_READ` rises. The first `INSTR_VALID` appears in cycle 3 at the earliest.
- `STALL` adds one EXEC cycle per cycle it is high. `INSTRUCTION` and `PC` are held throughout.
- The new `PC` is visible on `IMEM_ADDR` in the same cycle the FSM enters FETCH.
- `controlUnit` has a 1-time-unit internal decode delay. The branch inputs must therefore settle before the EXEC sampling edge.
  - The clock period must be greater than 1 time unit plus the ALU delay.
- Wrap-around: `PC`=2^PC_WIDTH−4 with a not-taken instruction goes to 0. A negative offset below 0 wraps modulo 2^PC_WIDTH.

## Structure
- A shared package `cpu_pkg` holds:
  - The state encoding (IDLE=2'b00, FETCH=2'b01, EXEC=2'b10).
  - The opcode field position [31:28] and the branch-offset field [7:0].
  - `PC_INCR`=4.
- Opcode constants are shared with `controlUnit`: BRANZ=4'b1001, BRAZ=4'b1010, BRAUNCOND=4'b1011.
- One sub-module, `next_pc_logic`, is purely combinational.
  - Inputs: PC, offset, `BRAZ`, `BRANZ`, `BRAUNCOND`, `ZERO`.
  - Output: next PC.
- The FSM and registers live in `fetch_unit`.

## Test plan
- Reset then straight-line fetch, `IMEM_BUSYWAIT`=0: `IMEM_ADDR` steps 0,1,2. `PC` steps 0,4,8, with `INSTR_VALID` pulsing every 2nd cycle. `INSTRUCTION` matches the memory contents 0x00000001, 0x10000005, ...
- Memory wait: hold `IMEM_BUSYWAIT`=1 for 3 cycles on the fetch at `PC`=8. Required: `IMEM_READ` stays high for 4 cycles, `IMEM_ADDR` stays 2, and `INSTRUCTION` updates only after `IMEM_BUSYWAIT` falls.
- Branches at `PC`=0x10 with offset 0x03:
  - `BRAZ`=1, `ZERO`=1: next `PC`=0x20.
  - `BRAZ`=1, `ZERO`=0: next `PC`=0x14.
  - `BRANZ`=1, `ZERO`=0: next `PC`=0x20.
  - `BRAUNCOND`=1 with `BRAZ`/`BRANZ` at X: next `PC`=0x20.
  - Offset 0xFC (−4), taken: next `PC`=0x04.
- `STALL`=1 for 2 cycles in EXEC: `INSTR_VALID` is high for 3 cycles, and `PC`/`INSTRUCTION` do not change. Exactly one PC update occurs after `STALL` drops.
- Assert `RESET` asynchronously mid-FETCH at `PC`=0x40 with `IMEM_BUSYWAIT`=1. Required: `IMEM_READ`, `INSTR_VALID` and `INSTRUCTION` go to 0 and `PC` goes to `RESET_PC`, all before the next edge. After release the sequence restarts with IDLE.
- Wrap-around: with `PC_WIDTH`=8 and `PC`=0xFC not taken, the next `PC` is 0x00.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, instruction fields, opcodes.
// Imported by the fetch stage and its next-PC helper.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10
    } fetch_state_t;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 28;
    localparam int OFFSET_MSB = 7;
    localparam int OFFSET_LSB = 0;
    localparam int PC_INCR    = 4;

    localparam logic [3:0] OP_BRANZ     = 4'b1001;
    localparam logic [3:0] OP_BRAZ      = 4'b1010;
    localparam logic [3:0] OP_BRAUNCOND = 4'b1011;

    // Unconditional wins outright so unknown conditional flags are ignored.
    function automatic logic branch_taken(
        input logic braz,
        input logic branz,
        input logic braunc,
        input logic zero
    );
        if (braunc)
            return 1'b1;
        return (braz & zero) | (branz & ~zero);
    endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC: sequential step plus optional word-scaled
// signed branch offset, all modulo 2^PC_WIDTH.
module next_pc_logic
    import cpu_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [7:0]          offset,
    input  logic                braz,
    input  logic                branz,
    input  logic                braunc,
    input  logic                zero,
    output logic [PC_WIDTH-1:0] next_pc
);

    logic [PC_WIDTH-1:0] soff;
    logic [PC_WIDTH-1:0] step;
    logic                taken;

    assign soff    = PC_WIDTH'($signed(offset));
    assign taken   = branch_taken(braz, branz, braunc, zero);
    assign step    = taken ? (soff << 2) : '0;
    assign next_pc = pc + PC_WIDTH'(PC_INCR) + step;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, busy-wait imem read, and a
// single execute slot that resolves branches from controlUnit.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned          PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
    parameter int unsigned          IMEM_AW  = 10
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                BRAZ,
    input  logic                BRANZ,
    input  logic                BRAUNCOND,
    input  logic                ZERO,
    input  logic                STALL,
    input  logic [31:0]         IMEM_READDATA,
    input  logic                IMEM_BUSYWAIT,
    output logic                IMEM_READ,
    output logic [IMEM_AW-1:0]  IMEM_ADDR,
    output logic [31:0]         INSTRUCTION,
    output logic                INSTR_VALID,
    output logic [PC_WIDTH-1:0] PC
);

    fetch_state_t        state;
    logic [PC_WIDTH-1:0] next_pc;

    assign IMEM_ADDR = PC[IMEM_AW+1:2];

    next_pc_logic #(
        .PC_WIDTH (PC_WIDTH)
    ) u_next_pc (
        .pc      (PC),
        .offset  (INSTRUCTION[OFFSET_MSB:OFFSET_LSB]),
        .braz    (BRAZ),
        .branz   (BRANZ),
        .braunc  (BRAUNCOND),
        .zero    (ZERO),
        .next_pc (next_pc)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            PC          <= RESET_PC;
            INSTRUCTION <= '0;
            IMEM_READ   <= 1'b0;
            INSTR_VALID <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state     <= FETCH;
                    IMEM_READ <= 1'b1;
                end
                FETCH: begin
                    if (!IMEM_BUSYWAIT) begin
                        INSTRUCTION <= IMEM_READDATA;
                        state       <= EXEC;
                        IMEM_READ   <= 1'b0;
                        INSTR_VALID <= 1'b1;
                    end
                end
                EXEC: begin
                    // next_pc is only consumed here, so branch inputs
                    // are don't-care in every other cycle.
                    if (!STALL) begin
                        PC          <= next_pc;
                        state       <= FETCH;
                        IMEM_READ   <= 1'b1;
                        INSTR_VALID <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    IMEM_READ   <= 1'b0;
                    INSTR_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a transaction-level PC model.
// Also exercises next_pc_logic at PC_WIDTH=8 for wrap-around.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        BRAZ, BRANZ, BRAUNCOND, ZERO, STALL;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic        IMEM_READ;
    logic [9:0]  IMEM_ADDR;
    logic [31:0] INSTRUCTION;
    logic        INSTR_VALID;
    logic [31:0] PC;

    logic [31:0] mem [1024];
    logic [31:0] exp_pc;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [7:0]  p8_pc, p8_off, p8_next;
    logic        p8_bz, p8_bnz, p8_unc, p8_z;

    always #5 CLK = ~CLK;

    assign IMEM_READDATA = IMEM_BUSYWAIT ? 32'hDEAD_BEEF : mem[IMEM_ADDR];

    fetch_unit dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .BRAZ          (BRAZ),
        .BRANZ         (BRANZ),
        .BRAUNCOND     (BRAUNCOND),
        .ZERO          (ZERO),
        .STALL         (STALL),
        .IMEM_READDATA (IMEM_READDATA),
        .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
        .IMEM_READ     (IMEM_READ),
        .IMEM_ADDR     (IMEM_ADDR),
        .INSTRUCTION   (INSTRUCTION),
        .INSTR_VALID   (INSTR_VALID),
        .PC            (PC)
    );

    next_pc_logic #(.PC_WIDTH(8)) u_np8 (
        .pc      (p8_pc),
        .offset  (p8_off),
        .braz    (p8_bz),
        .branz   (p8_bnz),
        .braunc  (p8_unc),
        .zero    (p8_z),
        .next_pc (p8_next)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic flags_x();
        BRAZ      = 1'bx;
        BRANZ     = 1'bx;
        BRAUNCOND = 1'bx;
        ZERO      = 1'bx;
    endtask

    task automatic do_reset();
        #2 RESET = 1'b1;
        #1;
        check("rst_rd",    IMEM_READ,   0);
        check("rst_vld",   INSTR_VALID, 0);
        check("rst_instr", INSTRUCTION, 0);
        check("rst_pc",    PC,          0);
        tick();
        RESET = 1'b0;
        IMEM_BUSYWAIT = 1'b0;
        STALL = 1'b0;
        check("idle_rd",  IMEM_READ,   0);
        check("idle_vld", INSTR_VALID, 0);
        tick();
        exp_pc = 32'h0;
    endtask

    // One instruction: fetch with `waits` busy cycles, exec with `stalls`.
    task automatic run_instr(input int waits, input int stalls,
                             input bit bz, input bit bnz,
                             input bit unc, input bit z);
        logic [9:0]        idx;
        logic [31:0]       instr;
        logic signed [7:0] off;
        bit                taken;
        idx = exp_pc[11:2];
        check("f_rd",   IMEM_READ,   1);
        check("f_vld",  INSTR_VALID, 0);
        check("f_addr", IMEM_ADDR,   idx);
        check("f_pc",   PC,          exp_pc);
        for (int w = 0; w < waits; w++) begin
            IMEM_BUSYWAIT = 1'b1;
            tick();
            check("w_rd",   IMEM_READ,   1);
            check("w_vld",  INSTR_VALID, 0);
            check("w_addr", IMEM_ADDR,   idx);
        end
        IMEM_BUSYWAIT = 1'b0;
        tick();
        instr = mem[idx];
        check("e_vld",   INSTR_VALID, 1);
        check("e_rd",    IMEM_READ,   0);
        check("e_instr", INSTRUCTION, instr);
        check("e_pc",    PC,          exp_pc);
        for (int s = 0; s < stalls; s++) begin
            STALL = 1'b1;
            flags_x();
            tick();
            check("s_vld",   INSTR_VALID, 1);
            check("s_instr", INSTRUCTION, instr);
            check("s_pc",    PC,          exp_pc);
        end
        STALL     = 1'b0;
        BRAUNCOND = unc;
        BRAZ      = unc ? 1'bx : bz;
        BRANZ     = unc ? 1'bx : bnz;
        ZERO      = z;
        taken = unc || (bz && z) || (bnz && !z);
        off   = instr[7:0];
        tick();
        flags_x();
        if (taken)
            exp_pc = exp_pc + 32'd4 + 32'(int'(off) * 4);
        else
            exp_pc = exp_pc + 32'd4;
    endtask

    task automatic goto_10();
        do_reset();
        for (int i = 0; i < 4; i++)
            run_instr(0, 0, 0, 0, 0, 0);
        check("at_10", PC, 32'h10);
    endtask

    initial begin
        flags_x();
        STALL = 1'b0;
        IMEM_BUSYWAIT = 1'b0;
        exp_pc = 32'h0;
        for (int i = 0; i < 1024; i++)
            mem[i] = $urandom;
        mem[0] = 32'h0000_0001;
        mem[1] = 32'h1000_0005;

        // Straight line, memory wait at PC=8, stall on the next one.
        do_reset();
        run_instr(0, 0, 0, 0, 0, 0);
        run_instr(0, 0, 0, 0, 0, 0);
        run_instr(3, 0, 0, 0, 0, 0);
        run_instr(0, 2, 0, 0, 0, 0);
        check("stall_next", PC, 32'h10);

        // Branches from 0x10 with offset 0x03 and 0xFC.
        mem[4] = {4'b1010, 20'h0, 8'h03};
        goto_10(); run_instr(0, 0, 1, 0, 0, 1); check("braz_t",  PC, 32'h20);
        goto_10(); run_instr(0, 0, 1, 0, 0, 0); check("braz_nt", PC, 32'h14);
        goto_10(); run_instr(0, 0, 0, 1, 0, 0); check("branz_t", PC, 32'h20);
        goto_10(); run_instr(0, 0, 0, 0, 1, 0); check("unc_t",   PC, 32'h20);
        mem[4] = {4'b1011, 20'h0, 8'hFC};
        goto_10(); run_instr(0, 0, 0, 0, 1, 1); check("neg_t",   PC, 32'h04);

        // Async reset mid-fetch at 0x40 while memory is busy.
        do_reset();
        for (int i = 0; i < 16; i++)
            run_instr(0, 0, 0, 0, 0, 0);
        check("at_40", PC, 32'h40);
        IMEM_BUSYWAIT = 1'b1;
        tick();
        check("b40_rd", IMEM_READ, 1);
        do_reset();
        run_instr(0, 0, 0, 0, 0, 0);

        // Randomized run.
        for (int i = 0; i < 300; i++) begin
            run_instr($urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) == 0), 1'($urandom));
        end

        // 8-bit wrap-around through the combinational helper.
        p8_pc = 8'hFC; p8_off = 8'h05;
        p8_bz = 1'b0; p8_bnz = 1'b0; p8_unc = 1'b0; p8_z = 1'b0;
        #1 check("wrap8_nt", {24'h0, p8_next}, 32'h00);
        p8_pc = 8'h00; p8_off = 8'hFC; p8_unc = 1'b1;
        #1 check("wrap8_neg", {24'h0, p8_next}, 32'hF4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
